axis_array_upsizer: RTL and testbench

//  Packs a narrow DMA read stream (IN_WIDTH bits per beat) into ARRAY_SIZE*DATA_WIDTH-bit words.

---
 rtl/axis_array_upsizer_if.sv | 13 +
 rtl/axis_array_upsizer.sv | 88 ++++++++
 tb/tb_axis_array_upsizer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/axis_array_upsizer_if.sv
// Valid/ready stream bundle used on both sides of the upsizer.
// W sets the data width, so the narrow input and the wide output share one definition.
interface axis_array_upsizer_if #(
   parameter int W = 64
);
   logic         valid;
   logic         ready;
   logic [W-1:0] data;
   logic         last;

   modport master (output valid, output data, output last, input  ready);
   modport slave  (input  valid, input  data, input  last, output ready);
endinterface

// File: rtl/axis_array_upsizer.sv
// Packs narrow DMA beats into one ARRAY_SIZE*DATA_WIDTH row word per output beat.
// The first beat lands in the least-significant slice. Short transfers are zero-padded and flagged.
module axis_array_upsizer #(
   parameter int DATA_WIDTH = 16,
   parameter int ARRAY_SIZE = 16,
   parameter int IN_WIDTH   = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clr,
   axis_array_upsizer_if.slave       s,
   axis_array_upsizer_if.master      m,
   output logic [15:0]               word_cnt,
   output logic                      partial_err
);
   localparam int OUT_W  = ARRAY_SIZE * DATA_WIDTH;
   localparam int RATIO  = OUT_W / IN_WIDTH;
   localparam int LANE_W = $clog2(RATIO);
   localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(RATIO - 1);

   logic [LANE_W-1:0] lane;
   logic [OUT_W-1:0]  pack;
   logic [OUT_W-1:0]  word_next;
   logic [OUT_W-1:0]  m_data_q;
   logic              m_valid_q;
   logic              m_last_q;
   logic              s_ready;
   logic              lane_last;
   logic              in_fire;
   logic              out_fire;
   logic              word_done;

   assign lane_last = (lane == LANE_MAX);

   // A completing beat is held back only while an earlier word is still stalled.
   assign s_ready   = !m_valid_q || m.ready || (!lane_last && !s.last);
   assign in_fire   = s.valid && s_ready;
   assign out_fire  = m_valid_q && m.ready;
   assign word_done = in_fire && (lane_last || s.last);

   assign s.ready = s_ready;
   assign m.valid = m_valid_q;
   assign m.data  = m_data_q;
   assign m.last  = m_last_q;

   // Slices above the current lane are still zero in pack, which gives the padding for free.
   always_comb begin
      word_next = pack;
      word_next[int'(lane) * IN_WIDTH +: IN_WIDTH] = s.data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         lane        <= '0;
         pack        <= '0;
         m_valid_q   <= 1'b0;
         m_data_q    <= '0;
         m_last_q    <= 1'b0;
         word_cnt    <= '0;
         partial_err <= 1'b0;
      end else begin
         if (in_fire) begin
            if (word_done) begin
               lane     <= '0;
               pack     <= '0;
               m_data_q <= word_next;
               m_last_q <= s.last;
               if (!lane_last) begin
                  partial_err <= 1'b1;
               end
            end else begin
               lane <= lane + LANE_W'(1);
               pack <= word_next;
            end
         end

         if (word_done) begin
            m_valid_q <= 1'b1;
         end else if (out_fire) begin
            m_valid_q <= 1'b0;
         end

         if (out_fire) begin
            word_cnt <= word_cnt + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_axis_array_upsizer.sv
// Randomised and directed bench for axis_array_upsizer against a beat-list reference model.
// Stimulus pushes expected words into a queue; an independent monitor pops them on each output handshake.
module tb_axis_array_upsizer;
   localparam int IW    = 64;
   localparam int OW    = 256;
   localparam int RATIO = OW / IW;

   typedef struct packed {
      logic [OW-1:0] data;
      logic          last;
   } word_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   logic [15:0] word_cnt;
   logic        partial_err;

   axis_array_upsizer_if #(.W(IW)) s_if ();
   axis_array_upsizer_if #(.W(OW)) m_if ();

   axis_array_upsizer #(.DATA_WIDTH(16), .ARRAY_SIZE(16), .IN_WIDTH(IW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (clr),
      .s           (s_if),
      .m           (m_if),
      .word_cnt    (word_cnt),
      .partial_err (partial_err)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   word_t       exp_q[$];
   logic [IW-1:0] cur[$];
   logic        ref_perr = 1'b0;
   logic [15:0] ref_cnt = 16'd0;

   function automatic void chk(string name, logic [OW-1:0] act, logic [OW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Reference: collect accepted beats; a word closes at RATIO beats or on last, zero-padded above.
   task automatic cycle(input logic v, input logic [IW-1:0] d, input logic l,
                        input logic mr, input logic c, output logic fired);
      logic [OW-1:0] w;
      @(negedge clk);
      chk("partial_err", OW'(partial_err), OW'(ref_perr));
      s_if.valid = v;
      s_if.data  = d;
      s_if.last  = l;
      m_if.ready = mr;
      clr        = c;
      #1;
      if (v && !c && !(cur.size() == RATIO - 1 || l))
         chk("noncompleting_ready", OW'(s_if.ready), OW'(1));
      fired = v && s_if.ready && !c;
      if (c) begin
         exp_q.delete();
         cur.delete();
         ref_perr = 1'b0;
      end else if (fired) begin
         cur.push_back(d);
         if (cur.size() == RATIO || l) begin
            w = '0;
            foreach (cur[i]) w[i*IW +: IW] = cur[i];
            if (cur.size() < RATIO) ref_perr = 1'b1;
            exp_q.push_back('{data: w, last: l});
            cur.delete();
         end
      end
   endtask

   task automatic send(input logic [IW-1:0] d, input logic l, input logic mr, output int tries);
      logic f;
      tries = 0;
      do begin
         cycle(1'b1, d, l, mr, 1'b0, f);
         tries++;
      end while (!f && tries < 200);
      if (!f) chk("send_timeout", OW'(0), OW'(1));
   endtask

   // Monitor: compares every output handshake, the running word count and stall stability.
   initial begin : monitor
      logic          prev_stall;
      logic [OW-1:0] prev_data;
      logic          prev_last;
      word_t         e;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_last  = 1'b0;
      wait (rst_n);
      forever begin
         @(negedge clk);
         #2;
         if (clr || !rst_n) begin
            ref_cnt    = 16'd0;
            prev_stall = 1'b0;
         end else begin
            chk("word_cnt", OW'(word_cnt), OW'(ref_cnt));
            if (prev_stall) begin
               chk("hold_data", m_if.data, prev_data);
               chk("hold_last", OW'(m_if.last), OW'(prev_last));
            end
            if (m_if.valid && m_if.ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_word", m_if.data, OW'(0) - OW'(1));
               end else begin
                  e = exp_q.pop_front();
                  chk("m_data", m_if.data, e.data);
                  chk("m_last", OW'(m_if.last), OW'(e.last));
               end
               ref_cnt = ref_cnt + 16'd1;
            end
            prev_stall = m_if.valid && !m_if.ready;
            prev_data  = m_if.data;
            prev_last  = m_if.last;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic f;
      int   n;
      int   acc;
      int   guard;
      int   first_try;
      s_if.valid = 1'b0;
      s_if.data  = '0;
      s_if.last  = 1'b0;
      m_if.ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_s_tready", OW'(s_if.ready), OW'(1));
      chk("rst_m_valid", OW'(m_if.valid), OW'(0));
      chk("rst_m_data", m_if.data, OW'(0));
      chk("rst_m_last", OW'(m_if.last), OW'(0));
      chk("rst_word_cnt", OW'(word_cnt), OW'(0));
      chk("rst_partial_err", OW'(partial_err), OW'(0));

      // T1: four beats form one word
      for (int i = 1; i <= 4; i++) send(IW'(i), 1'b0, 1'b1, n);
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, f);
      chk("t1_m_valid", OW'(m_if.valid), OW'(1));
      chk("t1_m_data", m_if.data, {IW'(4), IW'(3), IW'(2), IW'(1)});
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, f);
      chk("t1_word_cnt", OW'(word_cnt), OW'(1));

      // T2: 64 back-to-back beats, last on beat 64
      first_try = 0;
      for (int i = 0; i < 64; i++) begin
         send({32'hB0B0_0000, 32'(i)}, (i == 63), 1'b1, n);
         if (n == 1) first_try++;
      end
      chk("t2_no_backpressure", OW'(first_try), OW'(64));
      repeat (2) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, f);
      chk("t2_word_cnt", OW'(word_cnt), OW'(17));

      // T3: stall the first word while beats keep arriving
      for (int i = 1; i <= 4; i++) send(IW'(32'h300 + i), 1'b0, 1'b1, n);
      for (int i = 5; i <= 7; i++) begin
         send(IW'(32'h300 + i), 1'b0, 1'b0, n);
         chk("t3_accept_beat", OW'(n), OW'(1));
      end
      for (int i = 0; i < 7; i++) begin
         cycle(1'b1, IW'(32'h308), 1'b0, 1'b0, 1'b0, f);
         chk("t3_beat8_stall", OW'(f), OW'(0));
      end
      send(IW'(32'h308), 1'b0, 1'b1, n);
      repeat (3) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, f);

      // T4: short transfer padded and flagged
      send(IW'(32'hA), 1'b0, 1'b1, n);
      send(IW'(32'hB), 1'b1, 1'b1, n);
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, f);
      chk("t4_m_data", m_if.data, {IW'(0), IW'(0), IW'(32'hB), IW'(32'hA)});
      chk("t4_m_last", OW'(m_if.last), OW'(1));
      for (int i = 1; i <= 4; i++) send(IW'(32'h400 + i), (i == 4), 1'b1, n);
      repeat (2) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, f);
      chk("t4_sticky", OW'(partial_err), OW'(1));

      // T5: clear with a stalled word pending and a partial word in flight
      for (int i = 1; i <= 4; i++) send(IW'(32'h500 + i), 1'b0, 1'b1, n);
      send(IW'(32'h511), 1'b0, 1'b0, n);
      send(IW'(32'h512), 1'b0, 1'b0, n);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, f);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, f);
      chk("t5_m_valid", OW'(m_if.valid), OW'(0));
      chk("t5_word_cnt", OW'(word_cnt), OW'(0));
      chk("t5_partial_err", OW'(partial_err), OW'(0));
      for (int i = 1; i <= 4; i++) send(IW'(32'h520 + i), 1'b0, 1'b1, n);
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, f);
      chk("t5_clean_word", m_if.data, {IW'(32'h524), IW'(32'h523), IW'(32'h522), IW'(32'h521)});

      // T6: random valid/ready, 1000 accepted beats
      acc = 0;
      guard = 0;
      while (acc < 1000 && guard < 20000) begin
         cycle(1'($urandom % 2), {$urandom, $urandom}, ($urandom % 8) == 0,
               1'($urandom % 2), 1'b0, f);
         if (f) acc++;
         guard++;
      end
      chk("t6_beats", OW'(acc), OW'(1000));
      send({$urandom, $urandom}, 1'b1, 1'b1, n);
      repeat (10) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, f);
      chk("drain_expected_empty", OW'(exp_q.size()), OW'(0));
      chk("word_cnt_final", OW'(word_cnt), OW'(ref_cnt));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
